platform_map: RTL and testbench

PLATFORM_MAP -- requirements
Module: platform_map

---
 rtl/platform_pkg.sv | 32 +++
 rtl/platform_lfsr.sv | 32 +++
 rtl/platform_map.sv | 140 ++++++++++++++
 tb/tb_platform_map.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/platform_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// platform_pkg : grid geometry, map FSM state type and popcount helper.
// Revision     : 1.0
// ----------------------------------------------------------------------------
package platform_pkg;

  localparam int GRID_COLS   = 8;
  localparam int GRID_ROWS   = 6;
  localparam int SQUARE_SIZE = 90;
  localparam int SCREEN_W    = 640;
  localparam int SCREEN_H    = 480;
  localparam int MAP_BITS    = GRID_COLS * GRID_ROWS;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HIT    = 2'd1,
    ST_SCROLL = 2'd2,
    ST_FILL   = 2'd3
  } map_state_e;

  function automatic logic [5:0] map_popcount(input logic [MAP_BITS-1:0] m);
    logic [5:0] n;
    n = '0;
    for (int i = 0; i < MAP_BITS; i++) begin
      n = n + 6'(m[i]);
    end
    return n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/platform_lfsr.sv
`default_nettype none
// ----------------------------------------------------------------------------
// platform_lfsr : 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1), steps every clock.
// Revision      : 1.0
// ----------------------------------------------------------------------------
module platform_lfsr #(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       reset,
  output logic [7:0] value
);

  logic [7:0] lfsr_q;
  logic [7:0] lfsr_d;

  always_comb begin
    lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign value = lfsr_q;

endmodule
`default_nettype wire

// File: rtl/platform_map.sv
`default_nettype none
// ----------------------------------------------------------------------------
// platform_map : 8x6 platform occupancy grid with pixel lookup, hit clearing
//                and periodic downward scroll refilled from an LFSR.
// Revision     : 1.0
// ----------------------------------------------------------------------------
module platform_map
  import platform_pkg::*;
#(
  parameter int unsigned          SCROLL_PERIOD = 60,
  parameter logic [MAP_BITS-1:0]  INIT_MAP      = 48'h55AA55AA55AA,
  parameter logic [7:0]           LFSR_SEED     = 8'hA5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        startOfFrame,
  input  logic [10:0] pixelX,
  input  logic [10:0] pixelY,
  input  logic        hitReq,
  input  logic [2:0]  hitCol,
  input  logic [2:0]  hitRow,
  output logic        hitAck,
  output logic        DrawThisSquare,
  output logic        mapBusy,
  output logic [5:0]  platformCount
);

  map_state_e          state_q, state_d;
  logic [MAP_BITS-1:0] map_q, map_d;
  logic [7:0]          frame_cnt_q, frame_cnt_d;
  logic                scroll_pend_q, scroll_pend_d;
  logic                hit_ack_q, hit_ack_d;
  logic                draw_q, draw_d;
  logic [5:0]          count_q, count_d;

  logic [7:0]          lfsr_value;
  logic [2:0]          pix_col;
  logic [2:0]          pix_row;
  logic                pix_on_screen;
  logic                frame_wrap;

  platform_lfsr #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .value (lfsr_value)
  );

  // Square index by threshold comparison against multiples of the square size.
  always_comb begin
    pix_col = '0;
    pix_row = '0;
    for (int i = 1; i < GRID_COLS; i++) begin
      if (pixelX >= 11'(i * SQUARE_SIZE)) pix_col = 3'(i);
    end
    for (int i = 1; i < GRID_ROWS; i++) begin
      if (pixelY >= 11'(i * SQUARE_SIZE)) pix_row = 3'(i);
    end
  end

  assign pix_on_screen = (pixelX < 11'(SCREEN_W)) && (pixelY < 11'(SCREEN_H));
  assign frame_wrap    = startOfFrame && (frame_cnt_q == 8'(SCROLL_PERIOD - 1));

  always_comb begin
    state_d       = state_q;
    map_d         = map_q;
    hit_ack_d     = 1'b0;
    frame_cnt_d   = frame_cnt_q;
    scroll_pend_d = scroll_pend_q;
    draw_d        = pix_on_screen && map_q[{pix_row, pix_col}];

    if (startOfFrame) begin
      frame_cnt_d = frame_wrap ? 8'd0 : frame_cnt_q + 8'd1;
    end

    case (state_q)
      ST_IDLE: begin
        if (hitReq) begin
          state_d = ST_HIT;
        end else if (scroll_pend_q) begin
          state_d = ST_SCROLL;
        end
      end
      ST_HIT: begin
        if (hitRow < 3'(GRID_ROWS)) begin
          map_d[{hitRow, hitCol}] = 1'b0;
        end
        hit_ack_d = 1'b1;
        state_d   = ST_IDLE;
      end
      ST_SCROLL: begin
        map_d         = {map_q[MAP_BITS-GRID_COLS-1:0], map_q[GRID_COLS-1:0]};
        scroll_pend_d = 1'b0;
        state_d       = ST_FILL;
      end
      ST_FILL: begin
        map_d[GRID_COLS-1:0] = (lfsr_value == 8'h00) ? 8'h18 : lfsr_value;
        state_d              = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A wrap landing on the scroll cycle must survive the clear.
    if (frame_wrap) begin
      scroll_pend_d = 1'b1;
    end

    count_d = map_popcount(map_d);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      map_q         <= INIT_MAP;
      frame_cnt_q   <= 8'd0;
      scroll_pend_q <= 1'b0;
      hit_ack_q     <= 1'b0;
      draw_q        <= 1'b0;
      count_q       <= map_popcount(INIT_MAP);
    end else begin
      state_q       <= state_d;
      map_q         <= map_d;
      frame_cnt_q   <= frame_cnt_d;
      scroll_pend_q <= scroll_pend_d;
      hit_ack_q     <= hit_ack_d;
      draw_q        <= draw_d;
      count_q       <= count_d;
    end
  end

  assign hitAck         = hit_ack_q;
  assign DrawThisSquare = draw_q;
  assign mapBusy        = (state_q != ST_IDLE);
  assign platformCount  = count_q;

endmodule
`default_nettype wire

// File: tb/tb_platform_map.sv
`default_nettype none
// tb_platform_map : randomized bench for platform_map, checked against a
// row-array reference model of the grid, frame counter and row generator.
module tb_platform_map;

  localparam int          PERIOD = 2;
  localparam logic [47:0] INIT   = 48'h55AA55AA55AA;
  localparam logic [7:0]  SEED   = 8'hA5;
  localparam logic [7:0]  TAPS   = 8'b1011_1000; // x^8, x^6, x^5, x^4

  logic        clk          = 1'b0;
  logic        reset        = 1'b1;
  logic        startOfFrame = 1'b0;
  logic [10:0] pixelX       = '0;
  logic [10:0] pixelY       = '0;
  logic        hitReq       = 1'b0;
  logic [2:0]  hitCol       = '0;
  logic [2:0]  hitRow       = '0;
  logic        hitAck;
  logic        DrawThisSquare;
  logic        mapBusy;
  logic [5:0]  platformCount;

  always #5 clk = ~clk;

  platform_map #(
    .SCROLL_PERIOD (PERIOD),
    .INIT_MAP      (INIT),
    .LFSR_SEED     (SEED)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .startOfFrame   (startOfFrame),
    .pixelX         (pixelX),
    .pixelY         (pixelY),
    .hitReq         (hitReq),
    .hitCol         (hitCol),
    .hitRow         (hitRow),
    .hitAck         (hitAck),
    .DrawThisSquare (DrawThisSquare),
    .mapBusy        (mapBusy),
    .platformCount  (platformCount)
  );

  int          checks   = 0;
  int          failures = 0;
  logic [7:0]  rows_m [6];
  int          sof_cnt;
  bit          pend;
  logic [7:0]  lfsr_m;
  logic [47:0] init_v   = INIT;

  // Reference row generator: feedback is the parity of the tapped bits.
  always @(posedge clk) lfsr_m <= reset ? SEED : {lfsr_m[6:0], ^(lfsr_m & TAPS)};

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [47:0] model_map();
    logic [47:0] m;
    for (int r = 0; r < 6; r++) m[r*8 +: 8] = rows_m[r];
    return m;
  endfunction

  function automatic logic exp_pixel(input int x, input int y);
    if (x >= 640 || y >= 480) return 1'b0;
    return rows_m[y / 90][x / 90];
  endfunction

  task automatic model_reset();
    for (int r = 0; r < 6; r++) rows_m[r] = init_v[r*8 +: 8];
    sof_cnt = 0;
    pend    = 1'b0;
  endtask

  task automatic sof_model();
    if (sof_cnt == PERIOD - 1) begin
      sof_cnt = 0;
      pend    = 1'b1;
    end else begin
      sof_cnt++;
    end
  endtask

  task automatic probe(input int x, input int y, output logic d);
    pixelX = 11'(x);
    pixelY = 11'(y);
    @(negedge clk);
    d = DrawThisSquare;
  endtask

  task automatic check_map(input string tag, output logic [47:0] seen);
    logic d;
    for (int r = 0; r < 6; r++) begin
      for (int c = 0; c < 8; c++) begin
        probe(c * 90 + 5, r * 90 + 5, d);
        seen[r*8 + c] = d;
      end
    end
    chk({tag, "_map"}, seen, model_map());
    chk({tag, "_count"}, platformCount, $countones(model_map()));
  endtask

  task automatic do_reset();
    reset        = 1'b1;
    hitReq       = 1'b0;
    startOfFrame = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic pulse_sof();
    startOfFrame = 1'b1;
    @(negedge clk);
    startOfFrame = 1'b0;
    sof_model();
  endtask

  // sof_at: 0 none, 1 frame pulse alongside the request, 2 pulse during HIT
  task automatic do_hit(input logic [2:0] c, input logic [2:0] r, input int sof_at);
    int cycles;
    bit got;
    hitCol = c;
    hitRow = r;
    hitReq = 1'b1;
    if (sof_at == 1) startOfFrame = 1'b1;
    cycles = 0;
    got    = 1'b0;
    while (!got && cycles < 8) begin
      @(negedge clk);
      cycles++;
      if (startOfFrame) begin
        startOfFrame = 1'b0;
        sof_model();
      end
      if (cycles == 1) begin
        chk("hit_busy", mapBusy, 1);
        if (sof_at == 2) startOfFrame = 1'b1;
      end
      if (hitAck) got = 1'b1;
    end
    hitReq = 1'b0;
    chk("hit_ack_latency", got ? cycles : 99, 2);
    if (got && r < 6) rows_m[r][c] = 1'b0;
    @(negedge clk);
    chk("hit_ack_pulse", hitAck, 0);
  endtask

  task automatic run_scroll();
    int         t;
    int         n;
    logic [7:0] fill;
    t = 0;
    while (!mapBusy && t < 8) begin
      @(negedge clk);
      t++;
    end
    chk("scroll_start", mapBusy, 1);
    n    = 0;
    fill = 8'h00;
    while (mapBusy && n < 6) begin
      if (n == 1) fill = lfsr_m;
      n++;
      @(negedge clk);
    end
    chk("scroll_busy_len", n, 2);
    if (n == 2) begin
      for (int r = 5; r > 0; r--) rows_m[r] = rows_m[r-1];
      rows_m[0] = (fill == 8'h00) ? 8'h18 : fill;
      pend      = 1'b0;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [47:0] seen;
    logic        d;
    int          x, y, t;
    int          bx[8] = '{89, 90, 629, 630, 639, 640, 0, 799};
    int          by[8] = '{89, 90, 449, 450, 479, 480, 0, 599};

    // Reset state, with a pixel driven that would otherwise draw.
    pixelX = 11'd100;
    pixelY = 11'd80;
    repeat (3) @(negedge clk);
    chk("rst_count", platformCount, 24);
    chk("rst_busy", mapBusy, 0);
    chk("rst_ack", hitAck, 0);
    chk("rst_draw", DrawThisSquare, 0);
    reset = 1'b0;
    model_reset();

    probe(100, 80, d);  chk("pix_100_80", d, 1);
    probe(10, 80, d);   chk("pix_10_80", d, 0);
    probe(700, 100, d); chk("pix_700_100", d, 0);
    probe(100, 500, d); chk("pix_100_500", d, 0);
    check_map("init", seen);

    do_hit(3'd1, 3'd0, 0);
    chk("hit_count", platformCount, 23);
    probe(100, 80, d); chk("hit_pix_100_80", d, 0);

    for (int i = 0; i < 8; i++) begin
      probe(bx[i], 200, d); chk("edge_x", d, exp_pixel(bx[i], 200));
      probe(300, by[i], d); chk("edge_y", d, exp_pixel(300, by[i]));
    end
    for (int i = 0; i < 20; i++) begin
      x = $urandom_range(0, 799);
      y = $urandom_range(0, 599);
      probe(x, y, d);
      chk("rand_pix", d, exp_pixel(x, y));
    end

    // Two frame pulses produce one scroll and one refill.
    do_reset();
    pulse_sof();
    pulse_sof();
    chk("scroll_pending_model", pend, 1);
    run_scroll();
    check_map("scroll", seen);
    chk("scroll_row1", seen[15:8], 8'hAA);

    // Hit and scroll due together: hit is served first.
    do_reset();
    pulse_sof();
    do_hit(3'd0, 3'd1, 1);
    run_scroll();
    check_map("hit_then_scroll", seen);
    chk("hit_then_scroll_r2c0", seen[16], 0);

    // Frame wrap while the FSM is busy with a hit is not lost.
    pulse_sof();
    do_hit(3'($urandom_range(0, 7)), 3'($urandom_range(0, 5)), 2);
    run_scroll();
    check_map("sof_in_hit", seen);

    for (int it = 0; it < 12; it++) begin
      if ($urandom_range(0, 1) == 1) begin
        do_hit(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 0);
      end else begin
        pulse_sof();
        if (pend) run_scroll();
      end
      check_map($sformatf("rnd%0d", it), seen);
      for (int k = 0; k < 4; k++) begin
        x = $urandom_range(0, 799);
        y = $urandom_range(0, 599);
        probe(x, y, d);
        chk("rnd_pix", d, exp_pixel(x, y));
      end
    end

    // Reset landing on the SCROLL cycle discards the shift.
    t = 0;
    while (!pend && t < 4) begin
      pulse_sof();
      t++;
    end
    t = 0;
    while (!mapBusy && t < 8) begin
      @(negedge clk);
      t++;
    end
    chk("rst_scroll_seen", mapBusy, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    chk("rst_mid_busy", mapBusy, 0);
    chk("rst_mid_count", platformCount, 24);
    check_map("rst_mid", seen);
    chk("rst_mid_init", seen, 48'h55AA55AA55AA);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
